// File: rtl/quadtest_sysid_pkg.sv
// Shared constants for the QuadTest system-ID / uptime slave:
// register word addresses, CTRL bit positions and READ_COUNT limit.
package quadtest_sysid_pkg;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_UP_LO   = 3'd2;
  localparam logic [2:0] ADDR_UP_HI   = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;
  localparam logic [2:0] ADDR_RD_CNT  = 3'd6;
  localparam logic [2:0] ADDR_CAPS    = 3'd7;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam logic [31:0] RD_CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/quadtest_uptime_counter.sv
// Prescaled 64-bit uptime counter; one tick every PRESCALE enabled cycles.
// Ports: clock, reset (async high), en, clr (wins over tick), count[63:0].
module quadtest_uptime_counter #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  output logic [63:0] count
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic [63:0]   count_q, count_d;

  always_comb begin
    ps_d    = ps_q;
    count_d = count_q;
    if (clr) begin
      ps_d    = '0;
      count_d = '0;
    end else if (en) begin
      if (ps_q == PS_LAST) begin
        ps_d    = '0;
        count_d = count_q + 64'd1;
      end else begin
        ps_d = ps_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps_q    <= '0;
      count_q <= '0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/quadtest_sysid_ext.sv
// Avalon-MM system-ID / uptime slave with registered 1-cycle read path.
// Ports: clock, reset, address[2:0], read, write, writedata, byteenable,
//        readdata (registered), readdatavalid (1 cycle after read).
module quadtest_sysid_ext
  import quadtest_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0066,
  parameter logic [31:0] TIMESTAMP = 32'h5AFD_7B14,
  parameter logic [31:0] CAPS      = 32'h0000_0001,
  parameter int unsigned PRESCALE  = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [63:0] uptime;
  logic        wr_acc;
  logic        clr;
  logic [31:0] rd_cnt_inc;

  logic        en_q, en_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  // A read in the same cycle drops the write.
  assign wr_acc = write & ~read;
  assign clr    = wr_acc & (address == ADDR_CTRL)
                & writedata[CTRL_CLR];

  quadtest_uptime_counter #(
    .PRESCALE(PRESCALE)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .en   (en_q),
    .clr  (clr),
    .count(uptime)
  );

  assign rd_cnt_inc = (rd_cnt_q == RD_CNT_SAT)
                    ? rd_cnt_q : rd_cnt_q + 32'd1;

  always_comb begin
    en_d      = en_q;
    scratch_d = scratch_q;
    shadow_d  = shadow_q;
    rd_cnt_d  = rd_cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = read;

    if (wr_acc && address == ADDR_SCRATCH) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
      end
    end
    if (wr_acc && address == ADDR_CTRL) begin
      en_d = writedata[CTRL_EN];
    end

    if (clr) begin
      rd_cnt_d = '0;
    end else if (read) begin
      rd_cnt_d = rd_cnt_inc;
    end

    if (read) begin
      unique case (address)
        ADDR_ID:      rdata_d = SYSTEM_ID;
        ADDR_TS:      rdata_d = TIMESTAMP;
        ADDR_UP_LO: begin
          // Latch HI alongside LO so the pair is coherent.
          rdata_d  = uptime[31:0];
          shadow_d = uptime[63:32];
        end
        ADDR_UP_HI:   rdata_d = shadow_q;
        ADDR_SCRATCH: rdata_d = scratch_q;
        ADDR_CTRL:    rdata_d = {31'd0, en_q};
        // Count includes the read that returns it.
        ADDR_RD_CNT:  rdata_d = rd_cnt_inc;
        ADDR_CAPS:    rdata_d = CAPS;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b1;
      scratch_q <= '0;
      shadow_q  <= '0;
      rd_cnt_q  <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      en_q      <= en_d;
      scratch_q <= scratch_d;
      shadow_q  <= shadow_d;
      rd_cnt_q  <= rd_cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: doc/quadtest_sysid_ext.md
# quadtest_sysid_ext

Parametrised system-identification and uptime slave on the Avalon-MM control bus of the QuadTest system. Extends the fixed two-word ID/timestamp slave with a registered read path, a 64-bit prescaled uptime counter with atomic high-word capture, a writable scratch word, a control register and a read-activity counter. Software uses it to confirm the loaded image, check bus access and timestamp events.

## Interface

Parameters:
- SYSTEM_ID, 32'h0000_0066: value of the ID word.
- TIMESTAMP, 32'h5AFD_7B14: build timestamp word.
- CAPS, 32'h0000_0001: capability word; software-visible constant.
- PRESCALE, 50: clock cycles per uptime tick; legal range 1..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- read  in  1  read strobe, single cycle.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, one clock after an accepted read.

## Operation

- Register map, word addresses:
  - 0 ID (RO)
  - 1 TIMESTAMP (RO)
  - 2 UPTIME_LO (RO)
  - 3 UPTIME_HI (RO shadow)
  - 4 SCRATCH (RW, byte-enabled)
  - 5 CTRL (RW)
  - 6 READ_COUNT (RO)
  - 7 CAPS (RO)
- CTRL: bit0 EN, reset 1, enables uptime counting. Bit1 CLR is write-1, self-clearing, and reads as 0. Other bits read 0.
- Prescaler counts 0..PRESCALE-1 while EN=1. The 64-bit uptime increments on the terminal count. The prescaler holds its value while EN=0.
- Uptime wraps from 2^64-1 to 0 with no flag.
- Reading UPTIME_LO returns the live low word. On the same edge, the live high word is copied into the UPTIME_HI shadow. Reading UPTIME_HI returns the shadow only.
- READ_COUNT increments on every accepted read, saturates at 32'hFFFF_FFFF, and is cleared by CLR.
- Writes to RO addresses are ignored.
- If read and write are both high in one cycle, the read is serviced and the write is dropped.

## Timing

- Reset values: readdata=0, readdatavalid=0, SCRATCH=0, EN=1, uptime=0, prescaler=0, shadow=0, READ_COUNT=0.
- Read latency is exactly 1 cycle; there is no waitrequest, so a read is accepted every cycle.
- readdata holds its last value until the next read completes.
- Back-to-back reads give back-to-back readdatavalid pulses.
- A write takes effect at the clock edge where write is high; a read in the next cycle returns the new value.
- CLR zeroes uptime, prescaler and READ_COUNT on that edge. CLR has priority over a simultaneous increment.
- When a CLR write and a READ_COUNT update land on the same edge, the clear wins.
- UPTIME_LO read coinciding with an increment: the pre-increment LO value is returned and the pre-increment HI value is captured, so the pair is consistent.
- Disabling EN via CTRL stops counting from the next edge.
- Reset asserted mid-read: readdatavalid drops immediately, no pending response survives, and all state returns to reset values.

## Structure

- Package quadtest_sysid_pkg holds:
  - register address constants (ADDR_ID..ADDR_CAPS)
  - CTRL bit positions (CTRL_EN, CTRL_CLR)
  - the READ_COUNT saturation value
- Sub-module quadtest_uptime_counter (parameter PRESCALE) holds the prescaler and 64-bit counter.
  - Inputs: en, clr.
  - Output: count[63:0].
- The top level contains address decode, SCRATCH/CTRL registers, the shadow, READ_COUNT and the read-data register.

## Test plan

- Reset, then read addresses 0, 1 and 7: readdata is 32'h66, 32'h5AFD7B14 and 32'h1, each valid exactly 1 cycle after its read.
- PRESCALE=4, EN=1 for 40 cycles after reset, then read UPTIME_LO: value is 10 (±1 for the read edge), UPTIME_HI=0.
- Force uptime to 64'h0000_0000_FFFF_FFFF and let it tick, then read LO then HI: the pair reads 0/1, or FFFFFFFF/0 if read before the tick; never a mixed 0/0.
- Write SCRATCH=32'hDEADBEEF, then write 32'h00000011 with byteenable=4'b0001: reads back 32'hDEADBE11.
- Issue 5 reads, write CTRL=2'b11, then read READ_COUNT: returns 1 (counts only the post-clear read), and uptime restarts from 0.
- Write CTRL=0, wait 100 cycles: uptime is unchanged. Assert reset during a read: readdatavalid=0 and all registers read back their reset values.
